// File: rtl/uart_rx_sample_timer_if.sv
// uart_rx_sample_timer_if: control/status bundle between the RX FSM and the
// edge/bit sample timer. The resync line exists only when
// UART_RX_TIMER_RESYNC_EN is defined.
interface uart_rx_sample_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
`ifdef UART_RX_TIMER_RESYNC_EN
  logic                  resync;
`endif
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [2:0]            sample_stb;
  logic                  bit_done;
  logic                  frame_done;
  logic                  busy;
  logic                  cfg_err;

`ifdef UART_RX_TIMER_RESYNC_EN
  modport master (
    output en, prescale, frame_bits, resync,
    input  edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, busy, cfg_err
  );
  modport slave (
    input  en, prescale, frame_bits, resync,
    output edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, busy, cfg_err
  );
`else
  modport master (
    output en, prescale, frame_bits,
    input  edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, busy, cfg_err
  );
  modport slave (
    input  en, prescale, frame_bits,
    output edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, busy, cfg_err
  );
`endif
endinterface

// File: rtl/uart_rx_sample_timer.sv
// uart_rx_sample_timer: oversampling edge counter and frame bit counter for
// the UART receiver. Emits three centred sample strobes for majority voting
// plus bit-done / frame-done pulses. Prescale and frame length are latched at
// frame start; illegal values park the block in an error state.
// Optional feature macro: UART_RX_TIMER_RESYNC_EN (RX line edge realignment).
module uart_rx_sample_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_sample_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
  localparam logic [BIT_CNT_W-1:0]  B_ONE = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]  F_MIN = BIT_CNT_W'(2);

  state_t                state, state_nx;
  logic [PRESCALE_W-1:0] edge_q, edge_nx;
  logic [BIT_CNT_W-1:0]  bit_q, bit_nx;
  logic [PRESCALE_W-1:0] p_lat, p_nx;
  logic [BIT_CNT_W-1:0]  f_lat, f_nx;

  logic [PRESCALE_W-1:0] mid;
  logic                  run;
  logic                  wrap;
  logic                  last_bit;
  logic                  early;
  logic                  realign;
  logic                  adv;

  assign run      = (state == RUN);
  assign mid      = p_lat >> 1;
  assign wrap     = (edge_q == (p_lat - P_ONE));
  assign last_bit = (bit_q == (f_lat - B_ONE));

`ifdef UART_RX_TIMER_RESYNC_EN
  // A line edge in the late half closes the bit early; in the early half it
  // only pulls the edge counter back to the start of the current bit.
  assign early   = run && bus.resync && !wrap && (edge_q > mid);
  assign realign = run && bus.resync && !wrap && (edge_q != '0) && (edge_q <= mid);
`else
  assign early   = 1'b0;
  assign realign = 1'b0;
`endif

  assign adv = wrap || early;

  assign bus.edge_cnt      = edge_q;
  assign bus.bit_cnt       = bit_q;
  assign bus.busy          = run;
  assign bus.cfg_err       = (state == ERR);
  assign bus.bit_done      = run && adv;
  assign bus.frame_done    = run && adv && last_bit;
  assign bus.sample_stb[0] = run && (edge_q == (mid - P_ONE));
  assign bus.sample_stb[1] = run && (edge_q == mid);
  assign bus.sample_stb[2] = run && (edge_q == (mid + P_ONE));

  // State, counters and latched configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      edge_q <= '0;
      bit_q  <= '0;
      p_lat  <= '0;
      f_lat  <= '0;
    end else begin
      state  <= state_nx;
      edge_q <= edge_nx;
      bit_q  <= bit_nx;
      p_lat  <= p_nx;
      f_lat  <= f_nx;
    end
  end

  // Next-state and counter update; dropping en always returns to a clean IDLE.
  always_comb begin
    state_nx = state;
    edge_nx  = edge_q;
    bit_nx   = bit_q;
    p_nx     = p_lat;
    f_nx     = f_lat;
    if (!bus.en) begin
      state_nx = IDLE;
      edge_nx  = '0;
      bit_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          p_nx    = bus.prescale;
          f_nx    = bus.frame_bits;
          edge_nx = '0;
          bit_nx  = '0;
          if ((bus.prescale < P_MIN) || (bus.frame_bits < F_MIN)) begin
            state_nx = ERR;
          end else begin
            state_nx = RUN;
          end
        end
        RUN: begin
          if (adv) begin
            edge_nx = '0;
            if (last_bit) begin
              state_nx = DONE;
              bit_nx   = f_lat;
            end else begin
              bit_nx = bit_q + B_ONE;
            end
          end else if (realign) begin
            edge_nx = '0;
          end else begin
            edge_nx = edge_q + P_ONE;
          end
        end
        DONE: begin
          edge_nx = '0;
          bit_nx  = f_lat;
        end
        ERR: begin
          edge_nx = '0;
          bit_nx  = '0;
        end
        default: begin
          state_nx = IDLE;
          edge_nx  = '0;
          bit_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_sample_timer.md
Name: uart_rx_sample_timer

Overview:
Parametrised edge/bit timing generator for the UART receiver, successor to the fixed 5-bit/4-bit edge/bit counter. Counts oversampling clock edges within each bit and bits within a frame. Decodes three centred sample strobes for majority voting, plus bit-done and frame-done pulses. Configuration is latched per frame, and illegal configurations are flagged. Sits between the RX FSM (drives en) and the data sampler, deserializer and parity/stop checkers.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt; legal prescale range 4 .. 2^PRESCALE_W-1
BIT_CNT_W, 4, width of frame_bits and bit_cnt; legal frame_bits range 2 .. 2^BIT_CNT_W-1

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
en  input  1  frame enable from RX FSM; rising-level start, low aborts/clears
prescale  input  PRESCALE_W  oversampling ratio (clk edges per bit)
frame_bits  input  BIT_CNT_W  total bits per frame incl. start/parity/stop
edge_cnt  output  PRESCALE_W  edge index within current bit (registered)
bit_cnt  output  BIT_CNT_W  bit index within frame (registered)
sample_stb  output  3  bit i high when edge_cnt == mid-1+i, only in RUN
bit_done  output  1  high in RUN when edge_cnt == P-1
frame_done  output  1  high in RUN when edge_cnt == P-1 and bit_cnt == F-1
busy  output  1  high in RUN
cfg_err  output  1  high in ERR
resync  input  1  present only with UART_RX_TIMER_RESYNC_EN; RX line edge pulse

Behaviour:
- Reset: state IDLE; edge_cnt=0, bit_cnt=0, P_lat=0, F_lat=0; all strobes, busy, cfg_err = 0.
- States: IDLE, RUN, DONE, ERR. Counters and state registered; sample_stb/bit_done/frame_done/busy/cfg_err decoded combinationally from registers (zero latency).
- IDLE, en=1: latch P_lat=prescale, F_lat=frame_bits.
  - If prescale<4 or frame_bits<2: go to ERR.
  - Otherwise go to RUN with edge_cnt=0, bit_cnt=0.
  - The first RUN cycle shows edge_cnt=0.
- RUN:
  - edge_cnt increments each cycle.
  - When edge_cnt==P_lat-1: edge_cnt<=0 and bit_cnt<=bit_cnt+1.
  - If bit_cnt==F_lat-1 at that wrap: go to DONE with bit_cnt<=F_lat, edge_cnt<=0.
- mid = P_lat>>1 (floor). P_lat>=4 guarantees mid-1>=1 and mid+1<=P_lat-1.
- DONE: counters hold (edge_cnt=0, bit_cnt=F_lat). Stays until en=0; no automatic restart while en stays high.
- ERR: counters 0, cfg_err=1. Stays until en=0.
- en=0 in any state: next cycle IDLE, counters cleared to 0. Aborting mid-frame produces no frame_done.
- prescale/frame_bits changes while in RUN/DONE/ERR are ignored; only the latched values are used.
- Frame length: exactly P_lat*F_lat RUN cycles. bit_done pulses F_lat times; frame_done coincides with the last bit_done.
- Async reset mid-frame: immediate return to reset values.
- All arithmetic unsigned at the declared widths. bit_cnt never exceeds F_lat.

Optional Feature:
Macro UART_RX_TIMER_RESYNC_EN.
- Defined: resync port exists. In RUN, when resync=1 and bit_done=0:
  - edge_cnt > mid (late half): early boundary. edge_cnt<=0 and bit_cnt increments. The frame_done/DONE rule applies if bit_cnt==F_lat-1, and bit_done/frame_done assert that cycle.
  - 1 <= edge_cnt <= mid (early half): edge_cnt<=0, bit_cnt unchanged, no pulses.
  - edge_cnt==0: ignored.
  - resync coinciding with edge_cnt==P_lat-1: normal wrap only.
  - Ignored outside RUN.
- Undefined: no resync port; timing is free-running per the Behaviour section.

Test Plan:
- P=8, F=10, en held high → 80 RUN cycles. sample_stb=001/010/100 at edge_cnt 3/4/5 of each bit. 10 bit_done pulses; frame_done on cycle 80. DONE with bit_cnt=10 until en=0.
- P=5, F=2 → mid=2; strobes at edge_cnt 1,2,3; frame_done after 10 cycles.
- prescale=3 (or frame_bits=1) with en=1 → cfg_err=1, busy=0, counters 0. en=0 → IDLE with cfg_err=0.
- P=16, F=10; drop en at bit_cnt=4, edge_cnt=7 → next cycle IDLE, counters 0, no frame_done. Re-raise en → fresh frame from 0.
- Change prescale 8→16 at bit_cnt=2 → timing stays at 8; the new value takes effect next frame. Assert rst low mid-frame → all outputs 0 immediately.
- RESYNC_EN, P=16: resync at edge_cnt=12, bit_cnt=3 → next edge_cnt=0, bit_cnt=4, bit_done high that cycle. resync at edge_cnt=5 → edge_cnt=0, bit_cnt unchanged.
